// File: rtl/ast_wr_pkg.sv
// Shared constants, state encoding and beat-count helper for the Avalon-ST width reducer.
// Optional build macro used by the top: AST_WR_REG_READY_EN (registered sink ready).
package ast_wr_pkg;

    localparam int unsigned IN_BYTES  = 32;
    localparam int unsigned OUT_BYTES = 8;
    localparam int unsigned RATIO     = IN_BYTES / OUT_BYTES;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Number of narrow beats needed to carry the valid bytes of one wide word.
    // An out-of-range empty is illegal; clamp it to a single beat so the count never reaches zero.
    function automatic int unsigned beats_from_empty(
        input int unsigned empty,
        input int unsigned in_bytes,
        input int unsigned out_bytes
    );
        int unsigned valid_bytes;
        valid_bytes = (empty >= in_bytes) ? out_bytes : (in_bytes - empty);
        return (valid_bytes + out_bytes - 1) / out_bytes;
    endfunction

endpackage

// File: rtl/ast_wr_beat_calc.sv
// Combinational: input empty/eop -> index of the last emitted slice and the empty count on that slice.
import ast_wr_pkg::*;

module ast_wr_beat_calc #(
    parameter int unsigned IN_B        = 32,
    parameter int unsigned OUT_B       = 8,
    parameter int unsigned EMPTY_IN_W  = 5,
    parameter int unsigned EMPTY_OUT_W = 3,
    parameter int unsigned IDX_W       = 2
) (
    input  logic                   eop,
    input  logic [EMPTY_IN_W-1:0]  empty,
    output logic [IDX_W-1:0]       last_idx,
    output logic [EMPTY_OUT_W-1:0] last_empty
);

    always_comb begin
        int unsigned emp;
        int unsigned beats;
        emp        = 0;
        beats      = 0;
        last_idx   = '0;
        last_empty = '0;
        // empty is only meaningful on an EOP word
        emp        = eop ? 32'(empty) : 0;
        beats      = beats_from_empty(emp, IN_B, OUT_B);
        last_idx   = IDX_W'(beats - 1);
        last_empty = EMPTY_OUT_W'(beats * OUT_B - (IN_B - emp));
    end

endmodule

// File: rtl/ast_width_reducer.sv
// Avalon-ST width reducer: each accepted wide word is emitted as up to DATA_IN_W/DATA_OUT_W narrow slices.
// Build macro AST_WR_REG_READY_EN: registered ast_ready_o (one bubble per word) instead of combinational.
import ast_wr_pkg::*;

module ast_width_reducer #(
    parameter int unsigned DATA_IN_W   = 256,
    parameter int unsigned EMPTY_IN_W  = ((DATA_IN_W / 8) > 1) ? $clog2(DATA_IN_W / 8) : 1,
    parameter int unsigned CHANNEL_W   = 10,
    parameter int unsigned DATA_OUT_W  = 64,
    parameter int unsigned EMPTY_OUT_W = ((DATA_OUT_W / 8) > 1) ? $clog2(DATA_OUT_W / 8) : 1
) (
    input  logic                   clk_i,
    input  logic                   srst_i,
    input  logic [DATA_IN_W-1:0]   ast_data_i,
    input  logic                   ast_startofpacket_i,
    input  logic                   ast_endofpacket_i,
    input  logic                   ast_valid_i,
    input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
    input  logic [CHANNEL_W-1:0]   ast_channel_i,
    output logic                   ast_ready_o,
    output logic [DATA_OUT_W-1:0]  ast_data_o,
    output logic                   ast_startofpacket_o,
    output logic                   ast_endofpacket_o,
    output logic                   ast_valid_o,
    output logic [EMPTY_OUT_W-1:0] ast_empty_o,
    output logic [CHANNEL_W-1:0]   ast_channel_o,
    input  logic                   ast_ready_i
);

    localparam int unsigned IN_B   = DATA_IN_W / 8;
    localparam int unsigned OUT_B  = DATA_OUT_W / 8;
    localparam int unsigned NSLICE = DATA_IN_W / DATA_OUT_W;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t                               state_q;
    state_t                               state_d;
    logic [NSLICE-1:0][DATA_OUT_W-1:0]    slice_q;
    logic                                 sop_q;
    logic                                 eop_q;
    logic [CHANNEL_W-1:0]                 channel_q;
    logic [IDX_W-1:0]                     last_idx_q;
    logic [EMPTY_OUT_W-1:0]               last_empty_q;
    logic [IDX_W-1:0]                     cnt_q;

    logic [IDX_W-1:0]                     last_idx_c;
    logic [EMPTY_OUT_W-1:0]               last_empty_c;
    logic                                 last_slice;
    logic                                 out_fire;
    logic                                 accept;

    ast_wr_beat_calc #(
        .IN_B        (IN_B),
        .OUT_B       (OUT_B),
        .EMPTY_IN_W  (EMPTY_IN_W),
        .EMPTY_OUT_W (EMPTY_OUT_W),
        .IDX_W       (IDX_W)
    ) u_beat_calc (
        .eop        (ast_endofpacket_i),
        .empty      (ast_empty_i),
        .last_idx   (last_idx_c),
        .last_empty (last_empty_c)
    );

    assign last_slice = (cnt_q == last_idx_q);
    assign out_fire   = (state_q == SEND) && ast_ready_i;
    assign accept     = ast_valid_i && ast_ready_o;

`ifdef AST_WR_REG_READY_EN
    logic ready_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= (state_d == IDLE);
        end
    end

    assign ast_ready_o = ready_q;
`else
    // A new word may load on the same edge the last slice leaves, so back-to-back words have no bubble.
    assign ast_ready_o = (state_q == IDLE) || (last_slice && ast_ready_i);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = SEND;
            end
            SEND: begin
                if (ast_ready_i && last_slice) state_d = accept ? SEND : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q      <= IDLE;
            slice_q      <= '0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            channel_q    <= '0;
            last_idx_q   <= '0;
            last_empty_q <= '0;
            cnt_q        <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                slice_q      <= ast_data_i;
                sop_q        <= ast_startofpacket_i;
                eop_q        <= ast_endofpacket_i;
                channel_q    <= ast_channel_i;
                last_idx_q   <= last_idx_c;
                last_empty_q <= last_empty_c;
            end
            if (out_fire) begin
                cnt_q <= last_slice ? '0 : cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        ast_valid_o         = (state_q == SEND);
        ast_data_o          = slice_q[cnt_q];
        ast_startofpacket_o = ast_valid_o && sop_q && (cnt_q == '0);
        ast_endofpacket_o   = ast_valid_o && eop_q && last_slice;
        ast_empty_o         = ast_endofpacket_o ? last_empty_q : '0;
        ast_channel_o       = channel_q;
    end

endmodule

// File: tb/tb_ast_width_reducer.sv
// Directed scoreboard bench for ast_width_reducer (256 -> 64 bits, RATIO 4).
module tb_ast_width_reducer;

    localparam int unsigned DIN  = 256;
    localparam int unsigned DOUT = 64;
    localparam int unsigned CHW  = 10;
    localparam int unsigned EIW  = 5;
    localparam int unsigned EOW  = 3;
    localparam int unsigned RAT  = DIN / DOUT;

    typedef struct packed {
        logic [DOUT-1:0] data;
        logic            sop;
        logic            eop;
        logic [EOW-1:0]  empty;
        logic [CHW-1:0]  ch;
    } beat_t;

    logic            clk = 1'b0;
    logic            srst;
    logic [DIN-1:0]  data_i;
    logic            sop_i, eop_i, valid_i, ready_i;
    logic [EIW-1:0]  empty_i;
    logic [CHW-1:0]  ch_i;
    logic            ready_o;
    logic [DOUT-1:0] data_o;
    logic            sop_o, eop_o, valid_o;
    logic [EOW-1:0]  empty_o;
    logic [CHW-1:0]  ch_o;

    int    vectors = 0;
    int    miscompares = 0;
    int    beats_seen = 0;
    int    cyc = 0;
    int    last_beat_cyc = 0;
    bit    rand_rdy = 0;
    beat_t sb[$];
    beat_t held;
    bit    stall_pending = 0;

    ast_width_reducer #(
        .DATA_IN_W   (DIN),
        .EMPTY_IN_W  (EIW),
        .CHANNEL_W   (CHW),
        .DATA_OUT_W  (DOUT),
        .EMPTY_OUT_W (EOW)
    ) dut (
        .clk_i               (clk),
        .srst_i              (srst),
        .ast_data_i          (data_i),
        .ast_startofpacket_i (sop_i),
        .ast_endofpacket_i   (eop_i),
        .ast_valid_i         (valid_i),
        .ast_empty_i         (empty_i),
        .ast_channel_i       (ch_i),
        .ast_ready_o         (ready_o),
        .ast_data_o          (data_o),
        .ast_startofpacket_o (sop_o),
        .ast_endofpacket_o   (eop_o),
        .ast_valid_o         (valid_o),
        .ast_empty_o         (empty_o),
        .ast_channel_o       (ch_o),
        .ast_ready_i         (ready_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: at the falling edge, a valid&&ready beat is the one transferring on the next rising edge.
    always @(negedge clk) begin
        beat_t cur;
        beat_t exp;
        cur = '{data: data_o, sop: sop_o, eop: eop_o, empty: empty_o, ch: ch_o};
        if (!srst && valid_o) begin
            if (stall_pending) check("stall_hold", 128'(cur), 128'(held));
            if (ready_i) begin
                stall_pending = 0;
                if (sb.size() == 0) begin
                    check("unexpected_beat", 128'(cur), 128'(0));
                end else begin
                    exp = sb.pop_front();
                    check("beat", 128'(cur), 128'(exp));
                end
                beats_seen++;
                last_beat_cyc = cyc;
            end else begin
                held          = cur;
                stall_pending = 1;
            end
        end else begin
            stall_pending = 0;
        end
    end

    function automatic logic [DIN-1:0] rand_word();
        logic [DIN-1:0] r;
        for (int i = 0; i < DIN / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic push_word(input logic [DIN-1:0] d, input logic s, input logic e,
                             input int unsigned emp, input logic [CHW-1:0] ch);
        int unsigned vb;
        int unsigned nb;
        beat_t b;
        vb = e ? (DIN / 8 - emp) : DIN / 8;
        nb = (vb + DOUT / 8 - 1) / (DOUT / 8);
        for (int unsigned k = 0; k < nb; k++) begin
            b.data  = d[k*DOUT +: DOUT];
            b.sop   = s && (k == 0);
            b.eop   = e && (k == nb - 1);
            b.empty = b.eop ? EOW'(nb * (DOUT / 8) - vb) : '0;
            b.ch    = ch;
            sb.push_back(b);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
    endtask

    // Present one word and wait (bounded) for it to be accepted; returns 1 ns after the accepting edge.
    task automatic send_word(input logic [DIN-1:0] d, input logic s, input logic e,
                             input int unsigned emp, input logic [CHW-1:0] ch);
        bit acc;
        data_i  = d;
        sop_i   = s;
        eop_i   = e;
        empty_i = EIW'(emp);
        ch_i    = ch;
        valid_i = 1'b1;
        acc     = 0;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            acc = ready_o;
            if (acc) push_word(d, s, e, e ? emp : 0, ch);
            tick();
        end
        if (!acc) check("accept_timeout", 128'(0), 128'(1));
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 400) begin
            tick();
            t++;
        end
        check("drain_done", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        logic [DIN-1:0] w;
        int base;
        int c0;

        srst = 1'b1; valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
        empty_i = '0; ch_i = '0; data_i = '0; ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 srst = 1'b0;
        check("rst_valid", 128'(valid_o), 128'(0));
        check("rst_sop_eop", 128'({sop_o, eop_o}), 128'(0));
        check("rst_empty", 128'(empty_o), 128'(0));
        check("rst_data", 128'(data_o), 128'(0));
        check("rst_channel", 128'(ch_o), 128'(0));
        check("rst_ready", 128'(ready_o), 128'(1));

        // Full word, 4 beats, one-cycle latency to first valid
        w = rand_word();
        send_word(w, 1, 1, 0, 10'h011);
        check("latency_valid", 128'(valid_o), 128'(1));
        drain();

        // 12 valid bytes -> 2 beats, empty 4
        send_word(rand_word(), 1, 1, 20, 10'h022);
        drain();

        // Single-beat words at the boundary
        send_word(rand_word(), 1, 1, 24, 10'h033);
        drain();
        send_word(rand_word(), 1, 1, 31, 10'h034);
        drain();

        // Non-EOP empty ignored; 3-word packet under random backpressure
        rand_rdy = 1;
        send_word(rand_word(), 1, 0, 17, 10'h155);
        send_word(rand_word(), 0, 0, 0, 10'h155);
        send_word(rand_word(), 0, 1, 5, 10'h155);
        drain();
        rand_rdy = 0;
        ready_i  = 1'b1;
        tick();

        // Reset after two slices of a 4-slice word
        base = beats_seen;
        send_word(rand_word(), 1, 0, 0, 10'h0AA);
        tick();
        tick();
        check("beats_before_rst", 128'(beats_seen - base), 128'(2));
        srst    = 1'b1;
        ready_i = 1'b0;
        tick();
        check("rst_mid_valid", 128'(valid_o), 128'(0));
        check("rst_mid_eop", 128'(eop_o), 128'(0));
        srst    = 1'b0;
        ready_i = 1'b1;
        sb.delete();
        check("rst_mid_ready", 128'(ready_o), 128'(1));
        send_word(rand_word(), 1, 1, 8, 10'h0BB);
        drain();

        // Ten back-to-back single-word packets at full rate
        tick();
        base = beats_seen;
        send_word(rand_word(), 1, 1, 0, 10'h300);
        c0 = cyc;
        for (int i = 1; i < 10; i++) send_word(rand_word(), 1, 1, 0, CHW'(10'h300 + i));
        drain();
        check("b2b_beats", 128'(beats_seen - base), 128'(10 * RAT));
`ifdef AST_WR_REG_READY_EN
        // span ends on the last beat; the tenth word's bubble follows it
        check("b2b_cycles", 128'(last_beat_cyc - c0 + 1), 128'(10 * (RAT + 1) - 1));
`else
        check("b2b_cycles", 128'(last_beat_cyc - c0 + 1), 128'(10 * RAT));
`endif

        tick();
        check("idle_end_valid", 128'(valid_o), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
